// File: rtl/pwl_act_seq.sv
// pwl_act_seq: piecewise-linear sigmoid/tanh unit working on one sample at a time.
// It runs a binary search over an external breakpoint table, then computes y = a*|x| + b
// and applies the sign fix. Latency is fixed at 2*SW+5 cycles from accept to OUT_valid.
// Optional build macro: PWL_ROUND_EN. When it is defined, dropped product LSBs are
// rounded half-up. When it is undefined, they are truncated toward -inf.
module pwl_act_seq #(
  parameter int xDW  = 24,
  parameter int xFL  = 14,
  parameter int oDW  = 24,
  parameter int oFL  = 14,
  parameter int aDW  = 18,
  parameter int aFL  = 17,
  parameter int bDW  = 18,
  parameter int bFL  = 17,
  parameter int SW   = 8,
  parameter int XMAX = 16 << xFL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           IN_valid,
  output logic           IN_ready,
  input  logic           mode,
  input  logic [xDW-1:0] x_IN,
  output logic           tbl_rd,
  output logic           tbl_mode,
  output logic [SW-1:0]  tbl_addr,
  input  logic [xDW-1:0] tbl_bp,
  input  logic [aDW-1:0] tbl_a,
  input  logic [bDW-1:0] tbl_b,
  output logic [oDW-1:0] OUT,
  output logic           OUT_valid
);

  // The datapath width holds the full product plus the aligned intercept with headroom.
  localparam int PW    = aDW + xDW;
  localparam int WW    = PW + bDW + 2;
  localparam int SH    = aFL + xFL - oFL;
  localparam int BSH   = bFL - oFL;
  localparam int KW    = (SW > 1) ? $clog2(SW) : 1;
  localparam int RNDSH = (SH > 0) ? SH - 1 : 0;

  localparam logic [WW-1:0]  ONE    = WW'(1) << oFL;
  localparam logic [xDW-1:0] XMAX_V = xDW'(XMAX);
  localparam logic [xDW-1:0] XNEG   = {1'b1, {(xDW-1){1'b0}}};
  localparam logic [xDW-1:0] XPOS   = {1'b0, {(xDW-1){1'b1}}};
`ifdef PWL_ROUND_EN
  localparam logic [WW-1:0]  RND    = (SH > 0) ? (WW'(1) << RNDSH) : '0;
`else
  localparam logic [WW-1:0]  RND    = '0;
`endif
  localparam logic signed [WW:0] OMAX = $signed({{(WW+2-oDW){1'b0}}, {(oDW-1){1'b1}}});
  localparam logic signed [WW:0] OMIN = -OMAX - 1;

  typedef enum logic [2:0] {S_IDLE, S_CAP, S_SEARCH, S_FETCH, S_MUL, S_FIN} state_t;

  state_t          state;
  logic            phase;      // 0 = issue/read cycle, 1 = compare/capture cycle
  logic [KW-1:0]   bit_k;
  logic [SW-1:0]   idx;
  logic [xDW-1:0]  x_r;
  logic [xDW-1:0]  ax_r;
  logic            neg_r;
  logic            sat_r;
  logic [aDW-1:0]  a_r;
  logic [bDW-1:0]  b_r;

  logic [xDW-1:0]  ax_nx;
  logic [SW-1:0]   idx_nx;
  logic [WW-1:0]   p_full, p_sh, b_ext, b_al, y;
  logic signed [WW:0] ys, res;
  logic [oDW-1:0]  out_nx;

  // |x|. The most-negative code has no positive twin, so it folds to the largest positive value.
  always_comb begin
    ax_nx = x_r;
    if (x_r[xDW-1]) ax_nx = (x_r == XNEG) ? XPOS : (xDW'(0) - x_r);
  end

  // Search step: keep the probe when its breakpoint does not exceed |x|.
  always_comb begin
    idx_nx = idx;
    if ($signed(tbl_bp) <= $signed(ax_r)) idx_nx = tbl_addr;
  end

  // Intercept alignment from bFL to oFL. Extra fraction bits are truncated.
  assign b_ext = {{(WW-bDW){1'b0}}, b_r};
  generate
    if (BSH >= 0) begin : g_bdn
      assign b_al = b_ext >> BSH;
    end else begin : g_bup
      assign b_al = b_ext << (-BSH);
    end
  endgenerate

  // Product, optional rounding, sign fix and clamp. The result is registered into OUT.
  always_comb begin
    p_full = {{(WW-aDW){1'b0}}, a_r} * {{(WW-xDW){1'b0}}, ax_r};
    p_sh   = (p_full + RND) >> SH;
    y      = sat_r ? ONE : (p_sh + b_al);
    ys     = $signed({1'b0, y});
    res    = ys;
    if (neg_r) res = tbl_mode ? -ys : ($signed({1'b0, ONE}) - ys);
    if (res > OMAX)      out_nx = {1'b0, {(oDW-1){1'b1}}};
    else if (res < OMIN) out_nx = {1'b1, {(oDW-1){1'b0}}};
    else                 out_nx = res[oDW-1:0];
  end

  // Control FSM. Every table strobe and output is registered here.
  // FIN is the result cycle, and it also accepts the next sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      bit_k     <= '0;
      idx       <= '0;
      x_r       <= '0;
      ax_r      <= '0;
      neg_r     <= 1'b0;
      sat_r     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      IN_ready  <= 1'b1;
      tbl_rd    <= 1'b0;
      tbl_mode  <= 1'b0;
      tbl_addr  <= '0;
      OUT       <= '0;
      OUT_valid <= 1'b0;
    end else begin
      OUT_valid <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          if (IN_valid) begin
            x_r      <= x_IN;
            tbl_mode <= mode;
            IN_ready <= 1'b0;
            state    <= S_CAP;
          end else begin
            state    <= S_IDLE;
          end
        end
        S_CAP: begin
          ax_r     <= ax_nx;
          neg_r    <= x_r[xDW-1];
          sat_r    <= (ax_nx >= XMAX_V);
          idx      <= '0;
          bit_k    <= KW'(SW - 1);
          phase    <= 1'b0;
          tbl_rd   <= 1'b1;
          tbl_addr <= SW'(1) << (SW - 1);
          state    <= S_SEARCH;
        end
        S_SEARCH: begin
          if (!phase) begin
            tbl_rd <= 1'b0;
            phase  <= 1'b1;
          end else begin
            idx    <= idx_nx;
            phase  <= 1'b0;
            tbl_rd <= 1'b1;
            if (bit_k == '0) begin
              tbl_addr <= idx_nx;          // final segment read for a/b
              state    <= S_FETCH;
            end else begin
              tbl_addr <= idx_nx | (SW'(1) << (bit_k - 1'b1));
              bit_k    <= bit_k - 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (!phase) begin
            tbl_rd <= 1'b0;
            phase  <= 1'b1;
          end else begin
            a_r   <= tbl_a;
            b_r   <= tbl_b;
            phase <= 1'b0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          OUT       <= out_nx;
          OUT_valid <= 1'b1;
          IN_ready  <= 1'b1;
          state     <= S_FIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
